mc_regif: RTL and testbench

MC_REGIF -- requirements
Module: mc_regif

---
 rtl/mc_regif.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_regif.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_regif.sv
// mc_regif: AXI4-Lite register interface for the master controller.
// Registers (word offsets): 0x00 control RW, 0x04 debug RW, 0x08 status RO,
// 0x0C debug_status RO, 0x10 timestamp RO, 0x14 scratch RW; 0x18/0x1C unmapped.
// Ports:
//   clk_control, rst_control_n      - control clock, async active-low reset
//   s_aw*/s_w*/s_b*                 - AXI4-Lite write address/data/response
//   s_ar*/s_r*                      - AXI4-Lite read address/data
//   control, debug                  - register outputs (pulse bits self-clear)
//   status, debug_status, timestamp - read-only inputs (clk_control domain)
module mc_regif #(
    parameter logic [31:0] CTRL_PULSE_MASK  = 32'hE000_0000,
    parameter logic [31:0] DEBUG_PULSE_MASK = 32'h000F_018F
) (
    input  logic        clk_control,
    input  logic        rst_control_n,
    input  logic [4:0]  s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [4:0]  s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] control,
    output logic [31:0] debug,
    input  logic [31:0] status,
    input  logic [31:0] debug_status,
    input  logic [31:0] timestamp
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e            r_wstate, w_wstate_nxt;
    r_state_e            r_rstate, w_rstate_nxt;
    logic                r_aw_held, w_aw_held_nxt;
    logic                r_w_held, w_w_held_nxt;
    logic [IDX_W-1:0]    r_awidx, w_awidx_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [3:0]          r_wstrb, w_wstrb_nxt;
    logic                r_awready, w_awready_nxt;
    logic                r_wready, w_wready_nxt;
    logic                r_bvalid, w_bvalid_nxt;
    logic [1:0]          r_bresp, w_bresp_nxt;
    logic                r_arready, w_arready_nxt;
    logic                r_rvalid, w_rvalid_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic [1:0]          r_rresp, w_rresp_nxt;
    logic [DATA_W-1:0]   r_control, w_control_nxt;
    logic [DATA_W-1:0]   r_debug, w_debug_nxt;
    logic [DATA_W-1:0]   r_scratch, w_scratch_nxt;
    logic [DATA_W-1:0]   w_bytemask;
    logic                w_unused_addr_lsbs;

    // Byte lanes are word-aligned; the low address bits carry no information.
    assign w_unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign w_bytemask = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};

    // Write channel: independent AW/W capture, commit one edge after both are held.
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        w_awidx_nxt   = r_awidx;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        // Pulse bits fall back to 0 every cycle unless rewritten below.
        w_control_nxt = r_control & ~CTRL_PULSE_MASK;
        w_debug_nxt   = r_debug & ~DEBUG_PULSE_MASK;
        w_scratch_nxt = r_scratch;
        case (r_wstate)
            W_IDLE: begin
                if (r_aw_held && r_w_held) begin
                    w_bresp_nxt = RESP_OKAY;
                    case (r_awidx)
                        3'd0:    w_control_nxt = (w_control_nxt & ~w_bytemask) | (r_wdata & w_bytemask);
                        3'd1:    w_debug_nxt   = (w_debug_nxt & ~w_bytemask) | (r_wdata & w_bytemask);
                        3'd5:    w_scratch_nxt = (r_scratch & ~w_bytemask) | (r_wdata & w_bytemask);
                        default: w_bresp_nxt   = RESP_SLVERR;
                    endcase
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_wstate_nxt  = W_RESP;
                end else begin
                    if (s_awvalid && r_awready) begin
                        w_awidx_nxt   = s_awaddr[4:2];
                        w_aw_held_nxt = 1'b1;
                    end
                    if (s_wvalid && r_wready) begin
                        w_wdata_nxt  = s_wdata;
                        w_wstrb_nxt  = s_wstrb;
                        w_w_held_nxt = 1'b1;
                    end
                    w_awready_nxt = !w_aw_held_nxt;
                    w_wready_nxt  = !w_w_held_nxt;
                end
            end
            W_RESP: begin
                w_awready_nxt = 1'b0;
                w_wready_nxt  = 1'b0;
                if (s_bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read channel: data sampled at the AR edge, so same-edge writes read old values.
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                w_arready_nxt = 1'b1;
                if (s_arvalid && r_arready) begin
                    w_rresp_nxt = RESP_OKAY;
                    case (s_araddr[4:2])
                        3'd0:    w_rdata_nxt = r_control & ~CTRL_PULSE_MASK;
                        3'd1:    w_rdata_nxt = r_debug & ~DEBUG_PULSE_MASK;
                        3'd2:    w_rdata_nxt = status;
                        3'd3:    w_rdata_nxt = debug_status;
                        3'd4:    w_rdata_nxt = timestamp;
                        3'd5:    w_rdata_nxt = r_scratch;
                        default: begin
                            w_rdata_nxt = '0;
                            w_rresp_nxt = RESP_SLVERR;
                        end
                    endcase
                    w_rvalid_nxt  = 1'b1;
                    w_arready_nxt = 1'b0;
                    w_rstate_nxt  = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                    w_rstate_nxt  = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_control or negedge rst_control_n) begin
        if (!rst_control_n) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_control <= '0;
            r_debug   <= '0;
            r_scratch <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_rstate  <= w_rstate_nxt;
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_awidx   <= w_awidx_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
            r_control <= w_control_nxt;
            r_debug   <= w_debug_nxt;
            r_scratch <= w_scratch_nxt;
        end
    end

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign control   = r_control;
    assign debug     = r_debug;

endmodule

// File: tb/tb_mc_regif.sv
// tb_mc_regif: scoreboard bench for mc_regif. Stimulus tasks push expected
// B/R responses into queues; a negedge monitor pops and compares on each handshake.
module tb_mc_regif;

    localparam logic [31:0] DBG_MASK = 32'h000F_018F;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    typedef struct {
        string       name;
        logic [33:0] exp;
    } exp_t;

    logic        clk_control = 1'b0;
    logic        rst_control_n = 1'b0;
    logic [4:0]  s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b1;
    logic [4:0]  s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic [31:0] control;
    logic [31:0] debug;
    logic [31:0] status = 32'hA5A5_0001;
    logic [31:0] debug_status = 32'h0BAD_F00D;
    logic [31:0] timestamp = 32'h0000_1000;

    int checks = 0;
    int failures = 0;
    int b_hs = 0;
    int c31_hi = 0;
    int c31_rise = 0;
    int dbg_pulse = 0;
    logic c31_prev = 1'b0;
    exp_t bq[$];
    exp_t rq[$];

    mc_regif dut (
        .clk_control  (clk_control),
        .rst_control_n(rst_control_n),
        .s_awaddr     (s_awaddr),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_araddr     (s_araddr),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .control      (control),
        .debug        (debug),
        .status       (status),
        .debug_status (debug_status),
        .timestamp    (timestamp)
    );

    always #5 clk_control = ~clk_control;

    always @(posedge clk_control) timestamp <= timestamp + 32'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{control, debug, s_rdata, s_rresp, s_rvalid, s_bresp, s_bvalid,
                 s_awready, s_wready, s_arready};
    endfunction

    // Scoreboard monitor and pulse observers.
    always @(negedge clk_control) begin
        exp_t e;
        if (rst_control_n) begin
            if (s_bvalid && s_bready) begin
                b_hs++;
                if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                else begin
                    e = bq.pop_front();
                    chk(e.name, 64'(s_bresp), 64'(e.exp));
                end
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                else begin
                    e = rq.pop_front();
                    chk(e.name, 64'({s_rdata, s_rresp}), 64'(e.exp));
                end
            end
            if (control[31]) c31_hi++;
            if (control[31] && !c31_prev) c31_rise++;
            c31_prev = control[31];
            if ((debug & DBG_MASK) != 32'h0) dbg_pulse++;
        end
    end

    task automatic do_aw_w(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs;
        bit w_hs;
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        s_wvalid = 1'b1;
        s_awvalid = (aw_delay == 0);
        for (int n = 1; n < 100 && !(aw_done && w_done); n++) begin
            @(negedge clk_control);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge clk_control);
            #1;
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_wvalid = 1'b0;  w_done = 1;  end
            if (!aw_done && !s_awvalid && n >= aw_delay) s_awvalid = 1'b1;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!(aw_done && w_done)) chk("aw_w_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_b(input int hold);
        bit seen = 0;
        int held = 0;
        if (hold > 0) begin
            s_bready = 1'b0;
            for (int n = 0; n < 100 && !seen; n++) begin
                @(negedge clk_control);
                seen = s_bvalid;
                if (!seen) begin @(posedge clk_control); #1; end
            end
            if (seen) held = 1;
            for (int i = 1; i < hold; i++) begin
                @(posedge clk_control);
                @(negedge clk_control);
                if (s_bvalid) held++;
            end
            chk("bvalid_hold", 64'(held), 64'(hold));
            @(posedge clk_control);
            #1;
            s_bready = 1'b1;
        end
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk_control);
            seen = s_bvalid && s_bready;
            @(posedge clk_control);
            #1;
        end
        if (!seen) chk("b_timeout", 64'd0, 64'd1);
    endtask

    task automatic wr(input string name, input logic [4:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] resp,
                      input int aw_delay, input int hold);
        exp_t e;
        e.name = name;
        e.exp  = 34'(resp);
        bq.push_back(e);
        do_aw_w(addr, data, strb, aw_delay);
        wait_b(hold);
    endtask

    task automatic rd(input string name, input logic [4:0] addr, input logic [31:0] exp_d,
                      input logic [1:0] exp_r, input bit use_ts);
        bit hs = 0;
        exp_t e;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk_control);
            hs = s_arvalid && s_arready;
            if (hs) begin
                e.name = name;
                e.exp  = {(use_ts ? timestamp : exp_d), exp_r};
                rq.push_back(e);
            end
            @(posedge clk_control);
            #1;
        end
        s_arvalid = 1'b0;
        if (!hs) chk("ar_timeout", 64'd0, 64'd1);
        hs = 0;
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk_control);
            hs = s_rvalid && s_rready;
            @(posedge clk_control);
            #1;
        end
        if (!hs) chk("r_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int hi0;
        int rise0;
        int dbg0;
        int bh0;
        bit seen;

        // Reset state.
        #12;
        chk("reset_outputs", 64'(outs_nonzero()), 64'd0);
        @(posedge clk_control); #1;
        rst_control_n = 1'b1;
        @(posedge clk_control); #1;
        chk("ready_after_reset", 64'({s_awready, s_wready, s_arready}), 64'(3'b111));

        // Control pulse bit 31: single one-cycle pulse, reads back as 0.
        hi0 = c31_hi; rise0 = c31_rise;
        wr("b_ctrl_pulse", 5'h00, 32'h8000_0000, 4'hF, OKAY, 0, 0);
        chk("c31_high_cycles", 64'(c31_hi - hi0), 64'd1);
        chk("c31_rises", 64'(c31_rise - rise0), 64'd1);
        rd("r_ctrl_pulse", 5'h00, 32'h0, OKAY, 0);

        // Level bits hold; back-to-back pulse writes give two separate pulses.
        hi0 = c31_hi; rise0 = c31_rise;
        wr("b_ctrl_lvl1", 5'h00, 32'h8000_00FF, 4'hF, OKAY, 0, 0);
        wr("b_ctrl_lvl2", 5'h00, 32'h8000_00FF, 4'hF, OKAY, 0, 0);
        chk("c31_b2b_high", 64'(c31_hi - hi0), 64'd2);
        chk("c31_b2b_rises", 64'(c31_rise - rise0), 64'd2);
        chk("control_level", 64'(control), 64'h0000_00FF);
        rd("r_ctrl_lvl", 5'h00, 32'h0000_00FF, OKAY, 0);

        // Debug byte-strobe write, no pulse from level-only bits.
        dbg0 = dbg_pulse;
        wr("b_dbg1", 5'h04, 32'h0000_5000, 4'hF, OKAY, 0, 0);
        wr("b_dbg2", 5'h04, 32'h0000_2000, 4'b0010, OKAY, 0, 0);
        chk("debug_14_12", 64'(debug[14:12]), 64'(3'b010));
        chk("debug_no_pulse", 64'(dbg_pulse - dbg0), 64'd0);
        rd("r_dbg", 5'h04, 32'h0000_2000, OKAY, 0);
        dbg0 = dbg_pulse;
        wr("b_dbg_pulse", 5'h04, 32'h0000_0081, 4'b0001, OKAY, 0, 0);
        chk("debug_pulse_cycles", 64'(dbg_pulse - dbg0), 64'd1);
        rd("r_dbg_after_pulse", 5'h04, 32'h0000_2000, OKAY, 0);

        // W beat 3 cycles ahead of AW, bready held low for 5 cycles.
        bh0 = b_hs;
        wr("b_scratch_late_aw", 5'h14, 32'h1234_5678, 4'hF, OKAY, 3, 5);
        chk("b_handshakes", 64'(b_hs - bh0), 64'd1);
        rd("r_scratch", 5'h14, 32'h1234_5678, OKAY, 0);

        // wstrb=0 changes nothing; low address bits ignored.
        wr("b_strb0", 5'h14, 32'hFFFF_FFFF, 4'h0, OKAY, 0, 0);
        rd("r_scratch_lsb", 5'h17, 32'h1234_5678, OKAY, 0);

        // RO / unmapped accesses.
        rd("r_timestamp", 5'h10, 32'h0, OKAY, 1);
        rd("r_unmapped18", 5'h18, 32'h0, SLVERR, 0);
        rd("r_unmapped1c", 5'h1C, 32'h0, SLVERR, 0);
        wr("b_ro_status", 5'h08, 32'hFFFF_FFFF, 4'hF, SLVERR, 0, 0);
        wr("b_unmapped", 5'h1C, 32'hFFFF_FFFF, 4'hF, SLVERR, 0, 0);
        rd("r_status", 5'h08, 32'hA5A5_0001, OKAY, 0);
        rd("r_debug_status", 5'h0C, 32'h0BAD_F00D, OKAY, 0);

        // Read of scratch on the same edge as its update returns the old value.
        fork
            wr("b_scratch_conc", 5'h14, 32'hCAFE_0001, 4'hF, OKAY, 0, 0);
            begin
                @(posedge clk_control); #1;
                rd("r_scratch_conc_old", 5'h14, 32'h1234_5678, OKAY, 0);
            end
        join
        rd("r_scratch_new", 5'h14, 32'hCAFE_0001, OKAY, 0);

        // Reset while bvalid is pending and control[30] is pulsing.
        s_bready = 1'b0;
        do_aw_w(5'h00, 32'h4000_00FF, 4'hF, 0);
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk_control);
            seen = s_bvalid;
            if (!seen) begin @(posedge clk_control); #1; end
        end
        chk("ctrl30_pulse_bvalid", 64'({control[30], s_bvalid}), 64'(2'b11));
        #1;
        rst_control_n = 1'b0;
        #1;
        chk("reset_mid_outputs", 64'(outs_nonzero()), 64'd0);
        @(posedge clk_control);
        @(posedge clk_control); #1;
        rst_control_n = 1'b1;
        s_bready = 1'b1;
        @(posedge clk_control); #1;
        chk("ready_after_reset2", 64'({s_awready, s_wready, s_arready}), 64'(3'b111));
        chk("control_after_reset", 64'(control), 64'd0);
        rd("r_scratch_reset", 5'h14, 32'h0, OKAY, 0);
        wr("b_scratch_resume", 5'h14, 32'h0000_0055, 4'hF, OKAY, 0, 0);
        rd("r_scratch_resume", 5'h14, 32'h0000_0055, OKAY, 0);

        chk("bq_drained", 64'(bq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
